timer_multi: RTL

TIMER_MULTI -- requirements
Module: timer_multi

---
 rtl/timer_multi.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/timer_multi.sv
// Memory-mapped multi-channel timer: a prescaled 64-bit mtime counter feeding
// NumTimers compare channels, each either one-shot or periodic.
module timer_multi #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32,
  parameter int NumTimers    = 4,
  parameter int PrescWidth   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    timer_req_i,
  input  logic [AddressWidth-1:0] timer_addr_i,
  input  logic                    timer_we_i,
  input  logic [DataWidth/8-1:0]  timer_be_i,
  input  logic [DataWidth-1:0]    timer_wdata_i,
  output logic                    timer_rvalid_o,
  output logic [DataWidth-1:0]    timer_rdata_o,
  output logic                    timer_err_o,
  output logic                    timer_intr_o,
  output logic [NumTimers-1:0]    timer_intr_vec_o
);

  localparam logic [3:0]            NumTimersIdx = 4'(NumTimers);
  localparam logic [PrescWidth-1:0] PrescOne     = PrescWidth'(1);

  // Bus handshake: every access completes in the cycle it is requested.
  // rvalid follows req combinationally; rdata and err are meaningful only
  // while req is high and are driven to 0 otherwise.

  logic [9:0] offs;
  logic       sel_mtime_lo;
  logic       sel_mtime_hi;
  logic       sel_presc;
  logic       sel_status;
  logic       sel_enable;
  logic       sel_chan;
  logic [3:0] chan_idx;
  logic [1:0] chan_reg;
  logic       hit;
  logic       wr;

  assign offs         = timer_addr_i[9:0];
  assign sel_mtime_lo = (offs == 10'h000);
  assign sel_mtime_hi = (offs == 10'h004);
  assign sel_presc    = (offs == 10'h008);
  assign sel_status   = (offs == 10'h00C);
  assign sel_enable   = (offs == 10'h010);
  assign chan_idx     = offs[7:4];
  assign chan_reg     = offs[3:2];
  assign sel_chan     = (offs[9:8] == 2'b01) && (offs[1:0] == 2'b00) &&
                        (chan_idx < NumTimersIdx);
  assign hit          = sel_mtime_lo | sel_mtime_hi | sel_presc | sel_status |
                        sel_enable | sel_chan;
  assign wr           = timer_req_i && timer_we_i && hit;

  logic [63:0]           mtime_q, mtime_d;
  logic [PrescWidth-1:0] presc_cnt_q, presc_cnt_d;
  logic [PrescWidth-1:0] prescale_q, prescale_d;
  logic [NumTimers-1:0]  pending_q, pending_d;
  logic [NumTimers-1:0]  enable_q, enable_d;
  logic [NumTimers-1:0]  ctrl_en_q, ctrl_en_d;
  logic [NumTimers-1:0]  ctrl_per_q, ctrl_per_d;
  logic [63:0]           cmp_q    [NumTimers];
  logic [63:0]           cmp_d    [NumTimers];
  logic [31:0]           period_q [NumTimers];
  logic [31:0]           period_d [NumTimers];
  logic [NumTimers-1:0]  match;
  logic [NumTimers-1:0]  chan_we;
  logic [NumTimers-1:0]  w1c;
  logic                  presc_wr;
  logic                  tick;
  logic [31:0]           presc_merged;
  logic [31:0]           rdata;

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

  // Prescaler: a write restarts the count and suppresses that cycle's tick.
  assign presc_wr     = wr && sel_presc;
  assign presc_merged = merge_bytes(32'(prescale_q), timer_wdata_i, timer_be_i);
  assign tick         = !presc_wr && (presc_cnt_q == prescale_q);

  always_comb begin
    presc_cnt_d = presc_cnt_q + PrescOne;
    prescale_d  = prescale_q;
    if (presc_wr) begin
      presc_cnt_d = '0;
      prescale_d  = presc_merged[PrescWidth-1:0];
    end else if (presc_cnt_q == prescale_q) begin
      presc_cnt_d = '0;
    end
  end

  // The unwritten mtime half still picks up the increment and carry.
  always_comb begin
    mtime_d = mtime_q + {63'b0, tick};
    if (wr && sel_mtime_lo) begin
      mtime_d[31:0] = merge_bytes(mtime_q[31:0], timer_wdata_i, timer_be_i);
    end
    if (wr && sel_mtime_hi) begin
      mtime_d[63:32] = merge_bytes(mtime_q[63:32], timer_wdata_i, timer_be_i);
    end
  end

  always_comb begin
    for (int n = 0; n < NumTimers; n++) begin
      chan_we[n] = wr && sel_chan && (chan_idx == 4'(n));
    end
  end

  always_comb begin
    for (int n = 0; n < NumTimers; n++) begin
      match[n]      = ctrl_en_q[n] && (mtime_q >= cmp_q[n]);
      cmp_d[n]      = (match[n] && ctrl_per_q[n]) ?
                      cmp_q[n] + {32'b0, period_q[n]} : cmp_q[n];
      period_d[n]   = period_q[n];
      ctrl_en_d[n]  = ctrl_en_q[n] && !(match[n] && !ctrl_per_q[n]);
      ctrl_per_d[n] = ctrl_per_q[n];
      if (chan_we[n]) begin
        case (chan_reg)
          2'd0: cmp_d[n][31:0]  = merge_bytes(cmp_q[n][31:0], timer_wdata_i, timer_be_i);
          2'd1: cmp_d[n][63:32] = merge_bytes(cmp_q[n][63:32], timer_wdata_i, timer_be_i);
          2'd2: period_d[n]     = merge_bytes(period_q[n], timer_wdata_i, timer_be_i);
          default: begin
            // Any CTRL write overrides the one-shot auto-clear.
            ctrl_en_d[n]  = timer_be_i[0] ? timer_wdata_i[0] : ctrl_en_q[n];
            ctrl_per_d[n] = timer_be_i[0] ? timer_wdata_i[1] : ctrl_per_q[n];
          end
        endcase
      end
    end
  end

  // New matches are ORed after the clear so a coincident set survives W1C.
  assign w1c = (wr && sel_status && timer_be_i[0]) ? timer_wdata_i[NumTimers-1:0] : '0;

  always_comb begin
    pending_d = (pending_q & ~w1c) | match;
    enable_d  = (wr && sel_enable && timer_be_i[0]) ?
                timer_wdata_i[NumTimers-1:0] : enable_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_q     <= '0;
      presc_cnt_q <= '0;
      prescale_q  <= '0;
      pending_q   <= '0;
      enable_q    <= '0;
      ctrl_en_q   <= '0;
      ctrl_per_q  <= '0;
      for (int n = 0; n < NumTimers; n++) begin
        cmp_q[n]    <= '0;
        period_q[n] <= '0;
      end
    end else begin
      mtime_q     <= mtime_d;
      presc_cnt_q <= presc_cnt_d;
      prescale_q  <= prescale_d;
      pending_q   <= pending_d;
      enable_q    <= enable_d;
      ctrl_en_q   <= ctrl_en_d;
      ctrl_per_q  <= ctrl_per_d;
      for (int n = 0; n < NumTimers; n++) begin
        cmp_q[n]    <= cmp_d[n];
        period_q[n] <= period_d[n];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (timer_req_i && hit) begin
      if (sel_mtime_lo) rdata = mtime_q[31:0];
      if (sel_mtime_hi) rdata = mtime_q[63:32];
      if (sel_presc)    rdata = 32'(prescale_q);
      if (sel_status)   rdata = 32'(pending_q);
      if (sel_enable)   rdata = 32'(enable_q);
      for (int n = 0; n < NumTimers; n++) begin
        if (sel_chan && (chan_idx == 4'(n))) begin
          case (chan_reg)
            2'd0:    rdata = cmp_q[n][31:0];
            2'd1:    rdata = cmp_q[n][63:32];
            2'd2:    rdata = period_q[n];
            default: rdata = {30'b0, ctrl_per_q[n], ctrl_en_q[n]};
          endcase
        end
      end
    end
  end

  assign timer_rvalid_o   = timer_req_i;
  assign timer_rdata_o    = rdata;
  assign timer_err_o      = timer_req_i && !hit;
  assign timer_intr_vec_o = pending_q & enable_q;
  assign timer_intr_o     = |timer_intr_vec_o;

  logic unused_bits;
  assign unused_bits = ^{timer_addr_i[AddressWidth-1:10], presc_merged};

endmodule
